// File: rtl/if_pc_unit.sv
// ---------------------------------------------------------------------------
// if_pc_unit
//   Program-counter stage of the instruction-fetch path. Holds the PC, feeds
//   it to the external +1 incrementer and instruction memory, and selects the
//   next PC from the sequential, branch and jump sources. Handles hazard
//   stalls, single-step debug mode and HALT, and reports fetch validity,
//   redirect flushes and the number of cycles spent running.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   start_i           : leave IDLE and begin execution (level)
//   step_mode_i       : 0 = continuous run, 1 = single-step
//   step_i            : one advance permit per high cycle in step mode
//   stall_i           : hazard stall, hold PC this cycle
//   branch_i/_target_i: taken-branch redirect and destination
//   jump_i/_target_i  : jump redirect and destination (beats branch)
//   halt_i            : instruction at pc_o is HALT
//   pc_plus1_i        : incrementer result, used unmodified (wraps freely)
//   pc_o              : current PC
//   fetch_valid_o     : instruction at pc_o is consumed by IF/ID this cycle
//   flush_o           : registered one-cycle squash after an accepted redirect
//   halted_o          : block is in HALTED
//   cycle_count_o     : saturating count of clock edges spent in RUN
//
// Handshake: a redirect (jump_i/branch_i) is accepted only on a cycle where
// the PC advances; when it is not accepted (stall, step wait) it is not
// latched, so the requester must keep it asserted until an advancing cycle.
// ---------------------------------------------------------------------------
module if_pc_unit #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 step_mode_i,
  input  logic                 step_i,
  input  logic                 stall_i,
  input  logic                 branch_i,
  input  logic [PC_WIDTH-1:0]  branch_target_i,
  input  logic                 jump_i,
  input  logic [PC_WIDTH-1:0]  jump_target_i,
  input  logic                 halt_i,
  input  logic [PC_WIDTH-1:0]  pc_plus1_i,
  output logic [PC_WIDTH-1:0]  pc_o,
  output logic                 fetch_valid_o,
  output logic                 flush_o,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] cycle_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              state;
  logic                adv;
  logic                redirect;
  logic                halt_take;
  logic [PC_WIDTH-1:0] next_pc;

  // The PC moves only when running, not stalled, and (in step mode) permitted.
  assign adv       = (state == ST_RUN) && !stall_i && (!step_mode_i || step_i);
  assign redirect  = jump_i || branch_i;
  // A redirect squashes the HALT slot, so HALT only takes effect without one.
  assign halt_take = halt_i && !redirect;

  assign fetch_valid_o = adv && !halt_take;
  assign halted_o      = (state == ST_HALTED);

  always_comb begin
    next_pc = pc_plus1_i;
    if (jump_i)        next_pc = jump_target_i;
    else if (branch_i) next_pc = branch_target_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pc_o          <= RESET_PC;
      flush_o       <= 1'b0;
      cycle_count_o <= '0;
    end else begin
      flush_o <= adv && redirect;
      case (state)
        ST_IDLE: begin
          if (start_i) state <= ST_RUN;
        end
        ST_RUN: begin
          if (cycle_count_o != '1) cycle_count_o <= cycle_count_o + CNT_WIDTH'(1);
          if (adv) begin
            if (halt_take) state <= ST_HALTED;
            else           pc_o  <= next_pc;
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_if_pc_unit
//   Self-checking bench for if_pc_unit. A small behavioural model (running /
//   halted flags, expected PC, counter and flush) is advanced on every clock
//   edge from the same inputs the DUT sees; scenario tasks compare the DUT
//   against it and against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_if_pc_unit;
  localparam int PW = 8;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start, step_mode, step, stall, branch, jump, halt;
  logic [PW-1:0] branch_t, jump_t, pc_plus1;
  logic [PW-1:0] pc;
  logic          fetch_valid, flush, halted;
  logic [CW-1:0] cycle_count;

  if_pc_unit #(.PC_WIDTH(PW), .RESET_PC('0), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .step_mode_i(step_mode),
    .step_i(step), .stall_i(stall), .branch_i(branch),
    .branch_target_i(branch_t), .jump_i(jump), .jump_target_i(jump_t),
    .halt_i(halt), .pc_plus1_i(pc_plus1), .pc_o(pc),
    .fetch_valid_o(fetch_valid), .flush_o(flush), .halted_o(halted),
    .cycle_count_o(cycle_count)
  );

  int errors = 0;
  int checks = 0;

  // reference model
  bit            m_running, m_halted, m_flush;
  logic [PW-1:0] m_pc;
  logic [CW-1:0] m_cnt;

  function automatic logic exp_fv();
    bit moving;
    moving = m_running && !stall && (!step_mode || step);
    return moving && !(halt && !(jump || branch));
  endfunction

  // driver tasks
  task automatic drive(input logic st, input logic sm, input logic sp,
                       input logic stl, input logic br, input logic [PW-1:0] bt,
                       input logic jp, input logic [PW-1:0] jt, input logic hl);
    start = st; step_mode = sm; step = sp; stall = stl;
    branch = br; branch_t = bt; jump = jp; jump_t = jt; halt = hl;
    pc_plus1 = m_pc + PW'(1);
    #1;
  endtask

  task automatic tick();
    bit moving, redir;
    @(posedge clk);
    moving = m_running && !stall && (!step_mode || step);
    redir  = jump || branch;
    m_flush = moving && redir;
    if (m_running && m_cnt != CMAX) m_cnt = m_cnt + CW'(1);
    if (moving) begin
      if (halt && !redir) begin
        m_running = 0;
        m_halted  = 1;
      end else if (jump)   m_pc = jump_t;
      else if (branch)     m_pc = branch_t;
      else                 m_pc = pc_plus1;
    end
    if (!m_running && !m_halted && start) m_running = 1;
    #1;
  endtask

  task automatic model_reset();
    m_running = 0; m_halted = 0; m_flush = 0; m_pc = '0; m_cnt = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, '0, 0, '0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_run(input logic sm);
    drive(1, sm, 0, 0, 0, '0, 0, '0, 0);
    tick();
    drive(0, sm, 0, 0, 0, '0, 0, '0, 0);
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    checks++; if (pc !== '0) begin errors++; $display("FAIL reset_pc got=%h exp=00", pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (cycle_count !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cycle_count); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", fetch_valid); end
    // IDLE without start: nothing moves
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, '0, 0, '0, 0); tick(); end
    checks++; if (pc !== '0 || cycle_count !== '0) begin errors++; $display("FAIL idle_hold pc=%h cnt=%0d exp pc=00 cnt=0", pc, cycle_count); end
  endtask

  task automatic test_continuous();
    do_reset();
    start_run(0);
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL start_pc got=%h exp=00", pc); end
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 0, '0, 0, '0, 0);
      checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL run_fv got=%b exp=1", fetch_valid); end
      tick();
      checks++; if (pc !== PW'(i)) begin errors++; $display("FAIL run_pc got=%h exp=%h", pc, PW'(i)); end
    end
    checks++; if (cycle_count !== 4'd4) begin errors++; $display("FAIL run_cnt got=%0d exp=4", cycle_count); end
    drive(0, 0, 0, 0, 0, '0, 0, '0, 0); tick();   // pc = 5
    // stall two cycles at pc 5
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 0, '0, 0, '0, 0);
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_fv got=%b exp=0", fetch_valid); end
      tick();
      checks++; if (pc !== 8'h05) begin errors++; $display("FAIL stall_pc got=%h exp=05", pc); end
    end
    checks++; if (cycle_count !== 4'd7) begin errors++; $display("FAIL stall_cnt got=%0d exp=7", cycle_count); end
    drive(0, 0, 0, 0, 0, '0, 0, '0, 0); tick();
    checks++; if (pc !== 8'h06) begin errors++; $display("FAIL release_pc got=%h exp=06", pc); end
    // redirect held across a stall is not taken until the stall lifts
    drive(0, 0, 0, 1, 1, 8'h70, 0, '0, 0); tick();
    checks++; if (pc !== 8'h06 || flush !== 1'b0) begin errors++; $display("FAIL stalled_redirect pc=%h flush=%b exp pc=06 flush=0", pc, flush); end
    drive(0, 0, 0, 0, 0, '0, 0, '0, 0); tick();
    drive(0, 0, 0, 0, 0, '0, 0, '0, 0); tick();   // pc = 8
    drive(0, 0, 0, 0, 1, 8'h40, 1, 8'h80, 0);
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL redirect_fv got=%b exp=1", fetch_valid); end
    tick();
    checks++; if (pc !== 8'h80) begin errors++; $display("FAIL jump_prio_pc got=%h exp=80", pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL flush_on got=%b exp=1", flush); end
    drive(0, 0, 0, 0, 0, '0, 0, '0, 0); tick();
    checks++; if (flush !== 1'b0 || pc !== 8'h81) begin errors++; $display("FAIL flush_off flush=%b pc=%h exp flush=0 pc=81", flush, pc); end
    // wrap: incrementer result all-ones -> 0 accepted as-is
    drive(0, 0, 0, 0, 0, '0, 1, 8'hFF, 0); tick();
    drive(0, 0, 0, 0, 0, '0, 0, '0, 0); tick();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap_pc got=%h exp=00", pc); end
  endtask

  task automatic test_step();
    do_reset();
    start_run(1);
    for (int p = 1; p <= 3; p++) begin
      for (int w = 0; w < 2; w++) begin
        drive(0, 1, 0, 0, 0, '0, 0, '0, 0);
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL step_wait_fv got=%b exp=0", fetch_valid); end
        tick();
        checks++; if (pc !== PW'(p - 1)) begin errors++; $display("FAIL step_hold_pc got=%h exp=%h", pc, PW'(p - 1)); end
      end
      drive(0, 1, 1, 0, 0, '0, 0, '0, 0); tick();
      checks++; if (pc !== PW'(p)) begin errors++; $display("FAIL step_pc got=%h exp=%h", pc, PW'(p)); end
    end
    // step held three cycles -> three advances
    for (int i = 0; i < 3; i++) begin drive(0, 1, 1, 0, 0, '0, 0, '0, 0); tick(); end
    checks++; if (pc !== 8'h06) begin errors++; $display("FAIL step_held_pc got=%h exp=06", pc); end
  endtask

  task automatic test_halt();
    logic [CW-1:0] frozen;
    do_reset();
    start_run(0);
    drive(0, 0, 0, 0, 0, '0, 1, 8'h0C, 0); tick();
    drive(0, 0, 0, 0, 0, '0, 0, '0, 1);
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL halt_fv got=%b exp=0", fetch_valid); end
    tick();
    checks++; if (halted !== 1'b1 || pc !== 8'h0C) begin errors++; $display("FAIL halt_enter halted=%b pc=%h exp halted=1 pc=0c", halted, pc); end
    frozen = cycle_count;
    checks++; if (cycle_count !== m_cnt) begin errors++; $display("FAIL halt_cnt got=%0d exp=%0d", cycle_count, m_cnt); end
    for (int i = 0; i < 4; i++) begin drive(1, 0, 1, 0, 1, 8'h55, 1, 8'h66, 0); tick(); end
    checks++; if (halted !== 1'b1 || pc !== 8'h0C || cycle_count !== frozen || flush !== 1'b0) begin
      errors++; $display("FAIL halt_frozen halted=%b pc=%h cnt=%0d flush=%b exp 1/0c/%0d/0", halted, pc, cycle_count, flush, frozen);
    end
    // redirect beats halt in the same cycle
    do_reset();
    start_run(0);
    drive(0, 0, 0, 0, 1, 8'h20, 0, '0, 1); tick();
    checks++; if (pc !== 8'h20 || flush !== 1'b1 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_redirect pc=%h flush=%b halted=%b exp 20/1/0", pc, flush, halted);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    start_run(0);
    for (int i = 0; i < 20; i++) begin drive(0, 0, 0, 1, 0, '0, 0, '0, 0); tick(); end
    checks++; if (cycle_count !== CMAX || pc !== 8'h00) begin errors++; $display("FAIL saturate cnt=%0d pc=%h exp cnt=15 pc=00", cycle_count, pc); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    start_run(0);
    drive(0, 0, 0, 0, 0, '0, 1, 8'h33, 0); tick();
    checks++; if (pc !== 8'h33 || flush !== 1'b1) begin errors++; $display("FAIL pre_reset pc=%h flush=%b exp 33/1", pc, flush); end
    drive(0, 0, 0, 0, 0, '0, 0, '0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (pc !== '0 || flush !== 1'b0 || halted !== 1'b0 || cycle_count !== '0) begin
      errors++; $display("FAIL async_reset pc=%h flush=%b halted=%b cnt=%0d exp 00/0/0/0", pc, flush, halted, cycle_count);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, '0, 0, '0, 0); tick(); end
    checks++; if (pc !== '0 || cycle_count !== '0 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle pc=%h cnt=%0d fv=%b exp 00/0/0", pc, cycle_count, fetch_valid);
    end
  endtask

  task automatic test_random();
    logic sm;
    do_reset();
    sm = 1'($urandom_range(0, 1));
    for (int i = 0; i < 400; i++) begin
      if (m_halted && $urandom_range(0, 7) == 0) begin
        do_reset();
        sm = 1'($urandom_range(0, 1));
      end
      drive(1'($urandom_range(0, 1)), sm, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, PW'($urandom),
            $urandom_range(0, 7) == 0, PW'($urandom), $urandom_range(0, 24) == 0);
      checks++; if (fetch_valid !== exp_fv()) begin errors++; $display("FAIL rnd_fv cyc=%0d got=%b exp=%b", i, fetch_valid, exp_fv()); end
      tick();
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, pc, m_pc); end
      checks++; if (flush !== m_flush) begin errors++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", i, flush, m_flush); end
      checks++; if (halted !== m_halted) begin errors++; $display("FAIL rnd_halted cyc=%0d got=%b exp=%b", i, halted, m_halted); end
      checks++; if (cycle_count !== m_cnt) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, cycle_count, m_cnt); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_continuous();
    test_step();
    test_halt();
    test_saturate();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
